// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: forwarding
// encodings, the shadow-stage entry layout and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic                      valid;
    logic                      regwr;
    logic                      memtoreg;
    logic [REG_ADDR_W_DEF-1:0] wreg;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // Youngest producer wins; a WB producer reads the regfile because the
  // register file writes before it is read.
  function automatic logic [1:0] fwd_sel(input logic ex_alu_hit,
                                         input logic mem_hit,
                                         input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_alu_hit)   sel = FWD_MEM;
    else if (mem_hit) sel = FWD_WB;
    else if (wb_hit)  sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_dep_cmp.sv
// hazard_dep_cmp: does a shadow entry write register r? Register 0 never
// matches. is_load additionally flags that the producer is a load.
module hazard_dep_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  shadow_t                   entry,
  input  logic [REG_ADDR_W_DEF-1:0] r,
  output logic                      hit,
  output logic                      is_load
);

  assign hit     = entry.valid & entry.regwr & (entry.wreg == r) & (r != '0);
  assign is_load = hit & entry.memtoreg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch/jump flush and registered EX
// forwarding selects for a 5-stage MIPS pipeline. Optional performance
// counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_regwr,
  input  logic                  id_memtoreg,
  input  logic [REG_ADDR_W-1:0] id_wreg,
  input  logic                  id_jump,
  input  logic                  ex_br_taken,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  shadow_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  shadow_t               stage_ent [3];
  logic [REG_ADDR_W-1:0] src_reg   [2];
  logic [1:0]            hit       [3];
  logic [1:0]            hit_ld    [3];

  assign stage_ent[0] = ex_q;
  assign stage_ent[1] = mem_q;
  assign stage_ent[2] = wb_q;
  assign src_reg[0]   = id_rs;
  assign src_reg[1]   = id_rt;

  // One comparator per (stage, operand); index 0 = rs, 1 = rt.
  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    for (genvar gj = 0; gj < 2; gj++) begin : g_op
      hazard_dep_cmp u_cmp (
        .entry   (stage_ent[gi]),
        .r       (src_reg[gj]),
        .hit     (hit[gi][gj]),
        .is_load (hit_ld[gi][gj])
      );
    end
  end

  // Load flags of older stages do not matter: their data is already available.
  logic unused_older_ld;
  assign unused_older_ld = ^{hit_ld[1], hit_ld[2]};

  logic lu, jmp, load_ex;

  always_comb begin
    lu  = id_valid & ((id_uses_rs & hit_ld[0][0]) | (id_uses_rt & hit_ld[0][1]));
    jmp = id_valid & id_jump & ~ex_br_taken;

    pc_stall    = lu & ~ex_br_taken;
    ifid_stall  = lu & ~ex_br_taken;
    idex_bubble = ex_br_taken | lu;
    ifid_flush  = ex_br_taken | (jmp & ~lu);

    load_ex = id_valid & ~idex_bubble;
  end

  always_comb begin
    ex_d    = SHADOW_EMPTY;
    mem_d   = ex_q;
    wb_d    = mem_q;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (load_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.regwr    = id_regwr;
      ex_d.memtoreg = id_memtoreg;
      ex_d.wreg     = id_wreg;
      fwd_a_d = fwd_sel(hit[0][0] & ~hit_ld[0][0], hit[1][0], hit[2][0]);
      fwd_b_d = fwd_sel(hit[0][1] & ~hit_ld[0][1], hit[1][1], hit[2][1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= SHADOW_EMPTY;
      mem_q   <= SHADOW_EMPTY;
      wb_q    <= SHADOW_EMPTY;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl: one row per pipeline
// cycle of ID contents with hand-computed stall/flush/forward/counter values.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_regwr, id_memtoreg, id_jump, ex_br_taken;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_regwr(id_regwr), .id_memtoreg(id_memtoreg), .id_wreg(id_wreg),
    .id_jump(id_jump), .ex_br_taken(ex_br_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt;
    logic       urs, urt, regwr, mtr;
    logic [4:0] wreg;
    logic       jump, br;
    logic       e_pcs, e_ifs, e_fl, e_bub;
    logic [1:0] e_fa, e_fb;
    int         e_sc, e_fc;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  function automatic vec_t mk(input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input logic rw,
                              input logic mtr, input int wr, input logic j, input logic br,
                              input logic pcs, input logic ifs, input logic fl, input logic bub,
                              input int fa, input int fb, input int sc, input int fc);
    vec_t t;
    t.valid = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
    t.regwr = rw; t.mtr = mtr; t.wreg = 5'(wr); t.jump = j; t.br = br;
    t.e_pcs = pcs; t.e_ifs = ifs; t.e_fl = fl; t.e_bub = bub;
    t.e_fa = 2'(fa); t.e_fb = 2'(fb); t.e_sc = sc; t.e_fc = fc;
    return t;
  endfunction

  // Counter expectations collapse to zero when the counters are not built.
  function automatic logic [31:0] cexp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.valid; id_rs = t.rs; id_rt = t.rt;
    id_uses_rs = t.urs; id_uses_rt = t.urt;
    id_regwr = t.regwr; id_memtoreg = t.mtr; id_wreg = t.wreg;
    id_jump = t.jump; ex_br_taken = t.br;
  endtask

  task automatic check_all(input string tag, input vec_t t);
    chk({tag, " pc_stall"},    32'(pc_stall),    32'(t.e_pcs));
    chk({tag, " ifid_stall"},  32'(ifid_stall),  32'(t.e_ifs));
    chk({tag, " ifid_flush"},  32'(ifid_flush),  32'(t.e_fl));
    chk({tag, " idex_bubble"}, 32'(idex_bubble), 32'(t.e_bub));
    chk({tag, " fwd_a"},       32'(fwd_a),       32'(t.e_fa));
    chk({tag, " fwd_b"},       32'(fwd_b),       32'(t.e_fb));
    chk({tag, " stall_cnt"},   stall_cnt,        cexp(t.e_sc));
    chk({tag, " flush_cnt"},   flush_cnt,        cexp(t.e_fc));
  endtask

  initial begin
    //              v  rs  rt urs urt rw mtr wr  j br  pcs ifs fl bub fa fb sc fc
    tv[0]  = mk(0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0); // idle
    tv[1]  = mk(1, 29,  2, 1, 0, 1, 1,  2, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0); // lw $2
    tv[2]  = mk(1,  2,  4, 1, 1, 1, 0,  3, 0, 0,  1, 1, 0, 1,  0, 0, 0, 0); // add $3,$2,$4 load-use
    tv[3]  = mk(1,  2,  4, 1, 1, 1, 0,  3, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0); // add retried
    tv[4]  = mk(1,  3,  3, 1, 1, 1, 0,  5, 0, 0,  0, 0, 0, 0,  2, 0, 1, 0); // sub $5,$3,$3
    tv[5]  = mk(0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 0); // nop
    tv[6]  = mk(1,  5,  0, 1, 1, 1, 0,  6, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0); // or $6,$5,$0
    tv[7]  = mk(1, 29,  0, 1, 0, 1, 1,  0, 0, 0,  0, 0, 0, 0,  2, 0, 1, 0); // lw $0
    tv[8]  = mk(1,  0,  4, 1, 1, 1, 0,  3, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0); // add $3,$0,$4
    tv[9]  = mk(1,  6,  3, 1, 1, 1, 0,  7, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0); // and $7,$6,$3
    tv[10] = mk(1,  7,  8, 1, 0, 1, 1,  8, 0, 0,  0, 0, 0, 0,  0, 1, 1, 0); // lw $8,($7)
    tv[11] = mk(1,  8,  8, 1, 1, 1, 0,  9, 0, 1,  0, 0, 1, 1,  1, 0, 1, 0); // beq taken over lu
    tv[12] = mk(1,  0,  0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 1, 0,  0, 0, 1, 1); // j
    tv[13] = mk(1, 29, 10, 1, 0, 1, 1, 10, 0, 0,  0, 0, 0, 0,  0, 0, 1, 2); // lw $10
    tv[14] = mk(1, 10,  0, 1, 0, 0, 0,  0, 1, 0,  1, 1, 0, 1,  0, 0, 1, 2); // jump + lu: stall wins
    tv[15] = mk(1, 10,  0, 1, 0, 0, 0,  0, 1, 0,  0, 0, 1, 0,  0, 0, 2, 2); // jump retried
    tv[16] = mk(0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  2, 0, 2, 3); // nop
    tv[17] = mk(0,  0,  0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 1, 1,  0, 0, 2, 3); // branch alone

    rst = 1'b1;
    drive(tv[0]);
    #3;
    check_all("reset", tv[0]);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #3;
      check_all($sformatf("row%0d", i), tv[i]);
      $display("row %0d: stall=%0b flush=%0b bubble=%0b fwd_a=%0d fwd_b=%0d",
               i, pc_stall, ifid_flush, idex_bubble, fwd_a, fwd_b);
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a load-use stall.
    drive(mk(1, 29, 2, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("rst_seq pre pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_seq pre flush_cnt", flush_cnt, cexp(4));
    rst = 1'b1;
    #1;
    check_all("rst_seq during", mk(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("reset mid-stall: stall=%0b bubble=%0b stall_cnt=%0d", pc_stall, idex_bubble, stall_cnt);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("rst_seq after pc_stall",    32'(pc_stall),    32'd0);
    chk("rst_seq after idex_bubble", 32'(idex_bubble), 32'd0);
    @(posedge clk); #1;
    chk("rst_seq after fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_seq after stall_cnt", stall_cnt, cexp(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
